// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the decoder.
// Holds the fetch PC and issues one word fetch at a time to instruction
// memory (at most one request outstanding). Returned words are buffered
// with their addresses in a 2-entry FIFO whose head feeds the decoder.
// A redirect reloads the PC, flushes the FIFO and drops any stale response.
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight
// to the decoder in the same cycle when the FIFO is empty (0-cycle latency).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (current fetch PC)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  response word valid
//   imem_rdata   response instruction word
//   redirect_en  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   dec_ready    decoder consumes the presented instruction
//   inst         instruction to the decoder
//   inst_pc      address of inst
//   inst_valid   inst/inst_pc valid
module fetch_unit #(
  parameter int WORD_WIDTH = 32,
  parameter int W = WORD_WIDTH,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  input  logic         redirect_en,
  input  logic [W-1:0] redirect_pc,
  input  logic         dec_ready,
  output logic [W-1:0] inst,
  output logic [W-1:0] inst_pc,
  output logic         inst_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [W-1:0] req_addr;
  logic [W-1:0] fifo_pc   [2];
  logic [W-1:0] fifo_word [2];
  logic [1:0]   count;

  logic         fifo_valid;
  logic         rsp_ok;
  logic         bypass;
  logic         pop;
  logic         push;
  logic         space;
  logic         accept;
  logic         wr_idx;
  logic [W-1:0] redirect_aligned;

  assign fifo_valid       = (count != 2'd0);
  assign rsp_ok           = (state == WAIT) && imem_rvalid && !redirect_en;
  assign redirect_aligned = redirect_pc & ~(W'(3));

`ifdef FETCH_BYPASS_EN
  // Empty FIFO: the arriving word goes straight to the decoder.
  assign bypass     = rsp_ok && (count == 2'd0);
  assign inst       = bypass ? imem_rdata : fifo_word[0];
  assign inst_pc    = bypass ? req_addr   : fifo_pc[0];
  assign inst_valid = fifo_valid || bypass;
`else
  assign bypass     = 1'b0;
  assign inst       = fifo_word[0];
  assign inst_pc    = fifo_pc[0];
  assign inst_valid = fifo_valid;
`endif

  // A redirect voids any pop or push in its cycle; a bypassed word that the
  // decoder takes immediately never enters the FIFO.
  assign pop    = fifo_valid && dec_ready && !redirect_en;
  assign push   = rsp_ok && !(bypass && dec_ready);

  // Only IDLE can issue, so nothing is outstanding there; a same-cycle pop
  // frees an entry.
  assign space  = (count < 2'd2) || (fifo_valid && dec_ready);

  assign imem_req  = rst && (state == IDLE) && space;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Pushes only happen with count <= 1; after a pop the free slot is entry 0.
  assign wr_idx = count[0] && !pop;

  // Control: PC, outstanding-request FSM, occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
      count    <= 2'd0;
    end else begin
      if (redirect_en)
        pc <= redirect_aligned;
      else if (accept)
        pc <= pc + W'(4);

      if (accept)
        req_addr <= pc;

      if (redirect_en)
        count <= 2'd0;
      else
        count <= count + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (accept)
            state <= redirect_en ? DROP : WAIT;
        end
        WAIT: begin
          if (imem_rvalid)
            state <= IDLE;
          else if (redirect_en)
            state <= DROP;
        end
        DROP: begin
          if (imem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage: entry 0 is the head; a pop shifts entry 1 down, then a
  // push writes the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_word[0] <= '0;
      fifo_word[1] <= '0;
    end else begin
      if (pop) begin
        fifo_pc[0]   <= fifo_pc[1];
        fifo_word[0] <= fifo_word[1];
      end
      if (push) begin
        fifo_pc[wr_idx]   <= req_addr;
        fifo_word[wr_idx] <= imem_rdata;
      end
    end
  end

endmodule
